wrr_lock_arbiter: RTL and testbench
===================================

Name: wrr_lock_arbiter

Overview:
Parametrised successor to the single-grant round-robin arbiter in front of the SM atomic unit. It adds per-requester weights, so a requester can receive several back-to-back grants before priority rotates. It also adds a lock, so a multi-beat RMW sequence such as CAS load/compare/store cannot be split by another requester. It sits between per-line atomic request queues and the atomic RMW pipeline and uses the same valid/ack grant handshake.

Parameters:
NREQ, 8, number of requesters (at least 2).
WEIGHT_W, 3, width of each per-requester weight field.
IDX_W, clog2(NREQ), width of grant index (derived; do not override).

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  NREQ  request mask, bit i for requester i.
weight  in  NREQ*WEIGHT_W  packed weights; field i is bits [i*WEIGHT_W +: WEIGHT_W]; 0 is treated as 1.
lock  in  NREQ  requester i asks to keep the grant after the current ack.
ack  in  1  RMW pipeline accepted the current grant.
grant  out  NREQ  one-hot grant; zero when valid=0.
grant_idx  out  IDX_W  binary index of the granted requester; 0 when valid=0.
valid  out  1  a grant is presented.
locked  out  1  the current grant is a locked continuation.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - grant=0, grant_idx=0, valid=0, locked=0
  - ptr=0, credit=0, state=IDLE
- All outputs are registered.
- Winner selection: first set bit of req, searching ptr, ptr+1, … modulo NREQ.
- Latency: req seen in IDLE at cycle t gives valid=1 at t+1. No bubble between consecutive grants.
- States: IDLE, GRANT, LOCK.
- IDLE:
  - If req is nonzero: load the winner w, set credit = max(weight[w],1), go to GRANT.
  - Otherwise stay in IDLE.
- GRANT or LOCK, no ack: grant is held stable.
  - Exception: if req[g] drops while unacked, the grant is abandoned.
  - On abandonment: valid=0 next cycle, ptr=g+1, credit cleared, state=IDLE.
  - Abandonment is allowed in GRANT only. In LOCK, req[g] low is ignored.
- On ack, with g the current grantee, the next state is decided in this order:
  1. lock[g]=1: keep g, go to LOCK (locked=1), credit unchanged.
  2. credit>1 and req[g]=1: keep g, credit-1, go to GRANT, locked=0.
  3. Otherwise: ptr=g+1 mod NREQ, then reselect from the current req (g competes last).
     - If a winner exists: reload credit from its weight, go to GRANT.
     - If no winner: go to IDLE, valid=0.
- Weights are sampled only at credit load. Changes mid-burst take effect at the next load.
- credit is WEIGHT_W bits and never underflows; it is only decremented when greater than 1.
- The ptr wraps from NREQ-1 to 0.
- Fairness bound (no lock): a continuously requesting requester is granted within the sum of the other requesters' max(weight,1) acked grants.
- ack while valid=0 is ignored.
- grant, grant_idx, valid and locked are always mutually consistent.

Decomposition:
- Shared package atomic_arb_pkg holds:
  - the clog2 function
  - the state enum (IDLE, GRANT, LOCK)
  - a helper to extract weight field i
- One natural sub-module: rr_pick_first. It is a combinational rotating find-first-set with inputs (req, ptr) and outputs (found, idx). Both the IDLE path and the ack path reuse it.

Test Plan:
Bench configuration for all scenarios: NREQ=4, WEIGHT_W=3.
1. Reset then req=4'b1010, weights all 1, ack every valid cycle -> grants alternate idx 1, 3, 1, 3. First valid is the cycle after req. ptr wraps correctly.
2. req=4'b0011, weight0=3, weight1=1, ack every cycle -> grant sequence 0, 0, 0, 1, 0, 0, 0, 1 with no bubbles.
3. req=4'b0101, lock[0]=1 for two acks, then 0 -> idx 0 is granted 3 times; locked=1 on the 2nd and 3rd grants; then idx 2; req[0] dropped during LOCK is ignored.
4. Grant to idx 2, then req[2] dropped before ack -> valid=0 next cycle, then the next winner is searched from ptr=3.
5. reset asserted mid-burst (credit=2, valid=1) -> outputs clear immediately without a clock edge. After release, the first grant goes to the lowest set req bit from ptr=0.
6. weight2=0, req=4'b0100 alone -> one grant per credit load, so valid stays high continuously and credit never underflows. ack while valid=0 has no effect.

Source files
------------

// File: rtl/atomic_arb_pkg.sv
// Shared types and helpers for the weighted, lockable round-robin arbiter
// that sits in front of the SM atomic RMW pipeline.
package atomic_arb_pkg;

    localparam int MAX_VEC_W   = 256;
    localparam int MAX_FIELD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((32'sd1 <<< i) < n) ? i + 1 : r;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Field i of a packed weight vector; caller zero-extends the vector to MAX_VEC_W.
    function automatic logic [MAX_FIELD_W-1:0] weight_field(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   idx,
        input int                   wbits
    );
        logic [MAX_FIELD_W-1:0] f;
        int                     pos;
        f   = '0;
        pos = 0;
        for (int b = 0; b < MAX_FIELD_W; b++) begin
            pos  = idx * wbits + b;
            f[b] = (b < wbits && pos >= 0 && pos < MAX_VEC_W) ? vec[pos] : 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Rotating find-first-set: returns the first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick_first
    import atomic_arb_pkg::*;
#(
    parameter int NREQ  = 8,
    parameter int IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the farthest position back towards ptr so the nearest hit wins.
    always_comb begin : pick
        int  cand;
        logic hit;
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        hit     = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand    = int'(ptr_i) + k;
            cand    = (cand >= NREQ) ? cand - NREQ : cand;
            hit     = req_i[cand];
            found_o = found_o | hit;
            idx_o   = hit ? IDX_W'(cand) : idx_o;
        end
    end

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with lock for multi-beat atomic RMW sequences.
// All outputs are registered; grant/grant_idx/valid/locked move together.
module wrr_lock_arbiter
    import atomic_arb_pkg::*;
#(
    parameter int NREQ     = 8,
    parameter int WEIGHT_W = 3,
    parameter int IDX_W    = clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WEIGHT_W-1:0] weight,
    input  logic [NREQ-1:0]          lock,
    input  logic                     ack,
    output logic [NREQ-1:0]          grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     valid,
    output logic                     locked
);

    arb_state_e          state_q,  state_d;
    logic [IDX_W-1:0]    ptr_q,    ptr_d;
    logic [IDX_W-1:0]    gidx_q,   gidx_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [NREQ-1:0]     grant_q,  grant_d;
    logic                valid_q,  valid_d;
    logic                locked_q, locked_d;

    logic [MAX_VEC_W-1:0] weight_ext_s;
    logic [IDX_W-1:0]     ptr_next_s;
    logic                 idle_found_s, ack_found_s;
    logic [IDX_W-1:0]     idle_idx_s,   ack_idx_s;
    logic [WEIGHT_W-1:0]  idle_w_s,     ack_w_s;
    logic [WEIGHT_W-1:0]  idle_credit_s, ack_credit_s;
    logic                 req_g_s, lock_g_s;

    function automatic logic [NREQ-1:0] to_onehot(input logic [IDX_W-1:0] i);
        return {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    assign weight_ext_s = MAX_VEC_W'(weight);
    assign ptr_next_s   = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + IDX_W'(1);
    assign req_g_s      = req[gidx_q];
    assign lock_g_s     = lock[gidx_q];

    rr_pick_first #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_idle (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (idle_found_s),
        .idx_o   (idle_idx_s)
    );

    // Ack path searches from just past the grantee, so it competes last.
    rr_pick_first #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_ack (
        .req_i   (req),
        .ptr_i   (ptr_next_s),
        .found_o (ack_found_s),
        .idx_o   (ack_idx_s)
    );

    assign idle_w_s      = WEIGHT_W'(weight_field(weight_ext_s, int'(idle_idx_s), WEIGHT_W));
    assign ack_w_s       = WEIGHT_W'(weight_field(weight_ext_s, int'(ack_idx_s), WEIGHT_W));
    assign idle_credit_s = (idle_w_s == '0) ? WEIGHT_W'(1) : idle_w_s;
    assign ack_credit_s  = (ack_w_s == '0) ? WEIGHT_W'(1) : ack_w_s;

    // Next-state decision: load, hold, continue, rotate or abandon.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        credit_d = credit_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        locked_d = locked_q;
        case (state_q)
            IDLE: begin
                if (idle_found_s) begin
                    state_d  = GRANT;
                    gidx_d   = idle_idx_s;
                    grant_d  = to_onehot(idle_idx_s);
                    credit_d = idle_credit_s;
                    valid_d  = 1'b1;
                    locked_d = 1'b0;
                end else begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                end
            end
            GRANT, LOCK: begin
                if (ack) begin
                    if (lock_g_s) begin
                        state_d  = LOCK;
                        locked_d = 1'b1;
                    end else if (credit_q > WEIGHT_W'(1) && req_g_s) begin
                        state_d  = GRANT;
                        credit_d = credit_q - WEIGHT_W'(1);
                        locked_d = 1'b0;
                    end else begin
                        ptr_d = ptr_next_s;
                        if (ack_found_s) begin
                            state_d  = GRANT;
                            gidx_d   = ack_idx_s;
                            grant_d  = to_onehot(ack_idx_s);
                            credit_d = ack_credit_s;
                            valid_d  = 1'b1;
                            locked_d = 1'b0;
                        end else begin
                            state_d  = IDLE;
                            gidx_d   = '0;
                            grant_d  = '0;
                            credit_d = '0;
                            valid_d  = 1'b0;
                            locked_d = 1'b0;
                        end
                    end
                end else if (state_q == GRANT && !req_g_s) begin
                    // Requester withdrew before acceptance; a locked sequence cannot be abandoned.
                    state_d  = IDLE;
                    ptr_d    = ptr_next_s;
                    gidx_d   = '0;
                    grant_d  = '0;
                    credit_d = '0;
                    valid_d  = 1'b0;
                    locked_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d  = IDLE;
                ptr_d    = '0;
                gidx_d   = '0;
                grant_d  = '0;
                credit_d = '0;
                valid_d  = 1'b0;
                locked_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            credit_q <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = gidx_q;
    assign valid     = valid_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Directed bench for wrr_lock_arbiter with NREQ=4, WEIGHT_W=3.
module tb_wrr_lock_arbiter;

    localparam int NREQ     = 4;
    localparam int WEIGHT_W = 3;
    localparam int IDX_W    = 2;

    logic                     clk   = 1'b0;
    logic                     reset = 1'b1;
    logic [NREQ-1:0]          req   = '0;
    logic [NREQ*WEIGHT_W-1:0] weight = 12'o1111;
    logic [NREQ-1:0]          lock  = '0;
    logic                     ack   = 1'b0;
    logic [NREQ-1:0]          grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     valid;
    logic                     locked;

    int n_checks = 0;
    int n_errors = 0;

    wrr_lock_arbiter #(.NREQ(NREQ), .WEIGHT_W(WEIGHT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .weight    (weight),
        .lock      (lock),
        .ack       (ack),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (valid),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic v, input int idx, input logic lk);
        logic [NREQ-1:0] exp_grant;
        logic [31:0]     exp_idx;
        exp_grant = v ? (4'b0001 << idx) : 4'b0000;
        exp_idx   = v ? 32'(idx) : 32'd0;
        check_eq({tag, ".valid"},  32'(valid),     32'(v));
        check_eq({tag, ".idx"},    32'(grant_idx), exp_idx);
        check_eq({tag, ".grant"},  32'(grant),     32'(exp_grant));
        check_eq({tag, ".locked"}, 32'(locked),    32'(lk));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req    = '0;
        lock   = '0;
        ack    = 1'b0;
        weight = 12'o1111;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int seq2 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

        // 1: alternating grants with unit weights, ptr wrap
        do_reset();
        check_grant("s1.reset", 1'b0, 0, 1'b0);
        req = 4'b1010;
        ack = 1'b1;
        tick(); check_grant("s1.g0", 1'b1, 1, 1'b0);
        tick(); check_grant("s1.g1", 1'b1, 3, 1'b0);
        tick(); check_grant("s1.g2", 1'b1, 1, 1'b0);
        tick(); check_grant("s1.g3", 1'b1, 3, 1'b0);

        // 2: weight0=3 gives three back-to-back grants before rotating
        do_reset();
        weight = 12'o1113;
        req    = 4'b0011;
        ack    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_grant($sformatf("s2.g%0d", i), 1'b1, seq2[i], 1'b0);
        end

        // 3: lock holds requester 0 across two acks; req[0] drop ignored in LOCK
        do_reset();
        req  = 4'b0101;
        lock = 4'b0001;
        ack  = 1'b1;
        tick(); check_grant("s3.g0", 1'b1, 0, 1'b0);
        tick(); check_grant("s3.lk1", 1'b1, 0, 1'b1);
        req = 4'b0100;
        ack = 1'b0;
        tick(); check_grant("s3.drop", 1'b1, 0, 1'b1);
        ack = 1'b1;
        tick(); check_grant("s3.lk2", 1'b1, 0, 1'b1);
        lock = 4'b0000;
        tick(); check_grant("s3.rel", 1'b1, 2, 1'b0);

        // 4: abandonment in GRANT moves ptr past the grantee
        do_reset();
        req = 4'b0100;
        tick(); check_grant("s4.g0", 1'b1, 2, 1'b0);
        tick(); check_grant("s4.hold", 1'b1, 2, 1'b0);
        req = 4'b1001;
        tick(); check_grant("s4.abandon", 1'b0, 0, 1'b0);
        tick(); check_grant("s4.next", 1'b1, 3, 1'b0);

        // 5: asynchronous reset mid-burst clears outputs without a clock edge
        do_reset();
        weight = 12'o1113;
        req    = 4'b0011;
        ack    = 1'b1;
        tick(); check_grant("s5.g0", 1'b1, 0, 1'b0);
        tick(); check_grant("s5.g1", 1'b1, 0, 1'b0);
        reset = 1'b0;
        #1;
        check_grant("s5.async", 1'b0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0110;
        ack   = 1'b0;
        tick(); check_grant("s5.after", 1'b1, 1, 1'b0);
        ack = 1'b1;
        tick(); check_grant("s5.rot", 1'b1, 2, 1'b0);

        // 6: zero weight acts as one; ack while idle is ignored
        do_reset();
        weight = 12'o1011;
        req    = 4'b0000;
        ack    = 1'b1;
        tick(); check_grant("s6.idle0", 1'b0, 0, 1'b0);
        tick(); check_grant("s6.idle1", 1'b0, 0, 1'b0);
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant($sformatf("s6.g%0d", i), 1'b1, 2, 1'b0);
        end
        req = 4'b0101;
        tick(); check_grant("s6.mix0", 1'b1, 0, 1'b0);
        tick(); check_grant("s6.mix1", 1'b1, 2, 1'b0);
        req = 4'b0000;
        tick(); check_grant("s6.drain", 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
